// File: rtl/instr_mem_loader.sv
// Boot-time program loader and zero-latency instruction fetch responder.
// Bytes stream in little-endian, are packed into words and written to RAM.
module instr_mem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_sync,
    input  logic        load_start,
    input  logic [15:0] load_len,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        core_hold,
    output logic        load_done,
    output logic        load_err,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH);
    localparam logic [31:0] ADDR_LIM  = 32'(DEPTH * 4);

    typedef enum logic [1:0] {
        S_WAIT,
        S_LOAD,
        S_RUN
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] len_q, len_d;
    logic        core_hold_q, core_hold_d;
    logic        load_done_q, load_done_d;
    logic        load_err_q, load_err_d;
    logic [23:0] word_buf_q, word_buf_d;

    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        len_d       = len_q;
        load_err_d  = load_err_q;
        load_done_d = 1'b0;
        word_buf_d  = word_buf_q;
        mem_we      = 1'b0;
        mem_wdata   = {byte_data, word_buf_q};

        case (state_q)
            S_WAIT, S_RUN: begin
                if (load_start) begin
                    if (load_len == 16'd0) begin
                        state_d     = S_RUN;
                        load_done_d = 1'b1;
                        load_err_d  = 1'b0;
                    end else if ({1'b0, load_len} > DEPTH_LIM) begin
                        load_err_d = 1'b1;
                    end else begin
                        len_d      = load_len;
                        byte_cnt_d = 2'd0;
                        word_cnt_d = 16'd0;
                        load_err_d = 1'b0;
                        state_d    = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (byte_valid) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: word_buf_d[7:0]   = byte_data;
                        2'd1: word_buf_d[15:8]  = byte_data;
                        2'd2: word_buf_d[23:16] = byte_data;
                        default: begin
                            mem_we     = 1'b1;
                            word_cnt_d = word_cnt_q + 16'd1;
                            if (word_cnt_q == len_q - 16'd1) begin
                                state_d     = S_RUN;
                                load_done_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: state_d = S_WAIT;
        endcase

        core_hold_d = (state_d != S_RUN);
    end

    always_ff @(posedge clk or posedge rst_sync) begin
        if (rst_sync) begin
            state_q     <= S_WAIT;
            byte_cnt_q  <= 2'd0;
            word_cnt_q  <= 16'd0;
            len_q       <= 16'd0;
            core_hold_q <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            len_q       <= len_d;
            core_hold_q <= core_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // Partial-word bytes and RAM are pure data; a stale partial word is harmless
    // because the byte counter restarts at 0 after reset.
    always_ff @(posedge clk) begin
        word_buf_q <= word_buf_d;
        if (mem_we) begin
            mem[word_cnt_q[AW-1:0]] <= mem_wdata;
        end
    end

    always_comb begin
        instr = NOP_INSTR;
        if (state_q == S_RUN && instr_addr[1:0] == 2'b00 && instr_addr < ADDR_LIM) begin
            instr = mem[instr_addr[AW+1:2]];
        end
    end

    assign byte_ready = (state_q == S_LOAD);
    assign core_hold  = core_hold_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed plus randomized bench for instr_mem_loader; a word-level memory
// model built from the byte stream predicts every fetch.
module tb_instr_mem_loader;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_sync;
    logic        load_start;
    logic [15:0] load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        core_hold;
    logic        load_done;
    logic        load_err;
    logic [31:0] instr_addr;
    logic [31:0] instr;

    int total = 0;
    int bad   = 0;

    logic [7:0]  bq [$];
    logic [31:0] model_mem [DEPTH];
    bit          known [DEPTH];

    instr_mem_loader #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk        (clk),
        .rst_sync   (rst_sync),
        .load_start (load_start),
        .load_len   (load_len),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_err   (load_err),
        .instr_addr (instr_addr),
        .instr      (instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int nbytes);
        bq.delete();
        repeat (nbytes) bq.push_back(8'($urandom));
    endtask

    task automatic fill_fixed2();
        bq = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00};
    endtask

    function automatic logic [31:0] word_of(input int i);
        return {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
    endfunction

    task automatic start_load(input int len);
        instr_addr = 32'd0;
        load_start = 1'b1;
        load_len   = 16'(len);
        @(negedge clk);
        load_start = 1'b0;
        check("start_ready", byte_ready, 1);
        check("start_hold", core_hold, 1);
        check("start_err", load_err, 0);
        check("start_nop", instr, NOP);
    endtask

    // Streams 4*len bytes from bq with random gaps; noise injects ignored load_start pulses.
    task automatic run_load(input int len, input int maxgap, input bit noise);
        start_load(len);
        for (int i = 0; i < 4 * len; i++) begin
            int gaps;
            gaps = $urandom_range(maxgap, 0);
            repeat (gaps) begin
                byte_valid = 1'b0;
                load_start = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                load_len   = 16'($urandom_range(DEPTH + 4, 0));
                @(negedge clk);
                check("gap_ready", byte_ready, 1);
                check("gap_done", load_done, 0);
            end
            load_start = 1'b0;
            byte_valid = 1'b1;
            byte_data  = bq[i];
            @(negedge clk);
            if (i < 4 * len - 1) begin
                check("ld_done_early", load_done, 0);
                check("ld_hold", core_hold, 1);
                check("ld_nop", instr, NOP);
            end
        end
        byte_valid = 1'b0;
        check("done_pulse", load_done, 1);
        check("done_hold", core_hold, 0);
        check("done_ready", byte_ready, 0);
        check("done_err", load_err, 0);
        for (int i = 0; i < len; i++) begin
            model_mem[i] = word_of(i);
            known[i]     = 1'b1;
        end
        #1 check("done_instr_first", instr, model_mem[0]);
        instr_addr = 32'(4 * (len - 1));
        #1 check("done_instr_last", instr, model_mem[len-1]);
        instr_addr = 32'd0;
        @(negedge clk);
        check("done_once", load_done, 0);
    endtask

    task automatic sweep();
        for (int i = 0; i < DEPTH; i++) begin
            if (known[i]) begin
                @(negedge clk);
                instr_addr = 32'(i * 4);
                #1 check($sformatf("sweep_%0d", i), instr, model_mem[i]);
            end
        end
        instr_addr = 32'd0;
    endtask

    initial begin
        rst_sync   = 1'b1;
        load_start = 1'b0;
        load_len   = 16'd0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        instr_addr = 32'd0;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        check("rst_hold", core_hold, 1);
        check("rst_ready", byte_ready, 0);
        check("rst_instr", instr, NOP);
        check("rst_done", load_done, 0);
        check("rst_err", load_err, 0);
        rst_sync = 1'b0;
        byte_valid = 1'b1;
        byte_data  = 8'hAA;
        @(negedge clk);
        byte_valid = 1'b0;
        check("wait_hold", core_hold, 1);
        check("wait_ready", byte_ready, 0);

        // back-to-back two-word load
        fill_fixed2();
        run_load(2, 0, 0);
        instr_addr = 32'h0;
        #1 check("fix_w0", instr, 32'h0010_0093);
        instr_addr = 32'h4;
        #1 check("fix_w1", instr, 32'h0020_0113);

        // scramble, then the same load with bubbles and ignored load_start pulses
        fill_random(8);
        run_load(2, 0, 0);
        fill_fixed2();
        run_load(2, 3, 1);
        instr_addr = 32'h0;
        #1 check("gap_w0", instr, 32'h0010_0093);
        instr_addr = 32'h4;
        #1 check("gap_w1", instr, 32'h0020_0113);

        // full-depth load, then a shorter one leaving upper words intact
        fill_random(4 * DEPTH);
        run_load(DEPTH, 0, 0);
        sweep();
        fill_random(12);
        run_load(3, 2, 1);
        sweep();

        // zero-length load
        @(negedge clk);
        load_start = 1'b1;
        load_len   = 16'd0;
        @(negedge clk);
        load_start = 1'b0;
        check("len0_done", load_done, 1);
        check("len0_hold", core_hold, 0);
        check("len0_ready", byte_ready, 0);
        @(negedge clk);
        check("len0_once", load_done, 0);
        sweep();

        // oversize load is rejected, sticky error, memory unchanged
        load_start = 1'b1;
        load_len   = 16'(DEPTH + 1);
        @(negedge clk);
        load_start = 1'b0;
        check("big_err", load_err, 1);
        check("big_hold", core_hold, 0);
        check("big_ready", byte_ready, 0);
        check("big_done", load_done, 0);
        @(negedge clk);
        check("big_sticky", load_err, 1);
        sweep();
        fill_random(8);
        run_load(2, 1, 0);
        check("err_cleared", load_err, 0);

        // asynchronous reset after 5 bytes of a 2-word load
        start_load(2);
        fill_random(5);
        for (int i = 0; i < 5; i++) begin
            byte_valid = 1'b1;
            byte_data  = bq[i];
            @(negedge clk);
        end
        byte_valid   = 1'b0;
        model_mem[0] = word_of(0);
        known[0]     = 1'b1;
        rst_sync     = 1'b1;
        #1;
        check("arst_hold", core_hold, 1);
        check("arst_ready", byte_ready, 0);
        check("arst_done", load_done, 0);
        check("arst_instr", instr, NOP);
        @(negedge clk);
        rst_sync = 1'b0;
        @(negedge clk);
        check("arst_wait_hold", core_hold, 1);
        bq = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_load(1, 1, 0);
        check("arst_w0", instr, 32'h0000_0013);
        sweep();

        // fetch boundaries in RUN
        @(negedge clk);
        instr_addr = 32'(DEPTH * 4);
        #1 check("addr_oob", instr, NOP);
        instr_addr = 32'h2;
        #1 check("addr_misal", instr, NOP);
        instr_addr = 32'hFFFF_FFFC;
        #1 check("addr_huge", instr, NOP);
        instr_addr = 32'(DEPTH * 4 - 4);
        #1 check("addr_top", instr, model_mem[DEPTH-1]);

        // reload from RUN
        fill_random(4);
        run_load(1, 2, 0);
        sweep();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Instruction-memory responder for the RV core's fetch port, with a boot-time program loader. A byte-wide valid/ready stream is assembled little-endian into 32-bit words and written into a word-addressed RAM. While loading, the core is held in reset. Afterwards the block answers the core's `instr_addr` with `instr` combinationally, in the same cycle, as the fetch stage requires.

## Interface
- `DEPTH`, 1024: memory size in 32-bit words; power of two, max 65536. `AW = log2(DEPTH)`.
- `NOP_INSTR`, 32'h0000_0013: value returned when no valid fetch data exists.

- `clk` in 1: single clock, rising edge.
- `rst_sync` in 1: reset, asynchronous, active-high.
- `load_start` in 1: one-cycle request to begin a load; samples `load_len`.
- `load_len` in 16: number of words to load.
- `byte_valid` in 1: `byte_data` valid.
- `byte_data` in 8: program byte, little-endian order within each word.
- `byte_ready` out 1: loader accepts a byte this cycle.
- `core_hold` out 1: core reset request; drive the core's reset with it.
- `load_done` out 1: one-cycle pulse when a load completes.
- `load_err` out 1: sticky flag for a rejected load request.
- `instr_addr` in 32: byte address from the core's fetch stage.
- `instr` out 32: instruction word returned to the core.

## Operation
- FSM states: WAIT (reset state), LOAD, RUN.
- Reset values: state=WAIT, `core_hold`=1, `byte_ready`=0, `load_done`=0, `load_err`=0, byte/word counters=0, `instr`=`NOP_INSTR`.
- RAM contents are not reset.
- `byte_ready` = (state==LOAD). `core_hold` = (state!=RUN), registered.
- `load_start` is acted on in WAIT or RUN; it is ignored in LOAD.
  - `load_len`==0: go to RUN, pulse `load_done`, no writes, clear `load_err`.
  - `load_len`>`DEPTH`: set `load_err`; state unchanged; no writes.
  - Otherwise: latch `load_len`, clear counters and `load_err`, go to LOAD.
- Byte transfer occurs on (`byte_valid` && `byte_ready`) at the rising edge.
  - Byte k of a word (k=0..3) goes to bits [8k+7:8k].
  - The 2-bit byte counter wraps 3→0.
- On the 4th byte, write the word to `mem[word_cnt]` and increment `word_cnt`.
  - If this completes word `load_len`-1: go to RUN and pulse `load_done`.
- Words at index ≥ `load_len` keep their previous contents.
- Read path (combinational): if state==RUN, `instr_addr[1:0]`==0 and `instr_addr` < `DEPTH`*4, then `instr` = `mem[instr_addr[AW+1:2]]`. Otherwise `instr` = `NOP_INSTR`.
- A `load_start` in RUN (reload) re-asserts `core_hold`.
- A partially received word at reset is discarded.

## Timing
- Load request: `load_start` at edge N → state LOAD, `byte_ready`=1 and `core_hold`=1 from cycle N+1.
- A reload from RUN raises `core_hold` in cycle N+1.
- Byte throughput: one byte per cycle. `byte_valid` may drop at any time and bubbles are tolerated.
- Completion: the last byte is accepted at edge M. In cycle M+1: `load_done`=1 for one cycle, `core_hold`=0, `byte_ready`=0. `instr` reflects the new contents the same cycle.
- `load_len`==0: `load_done` and `core_hold`=0 appear in the cycle after `load_start`.
- `load_err` rises the cycle after a rejected `load_start`.
- Fetch: zero-cycle latency, `instr_addr` → `instr`.
- `rst_sync` asserted mid-LOAD: immediately (asynchronously) returns to WAIT with all reset values. The next `load_start` restarts from word 0, byte 0.
- `byte_valid` with `byte_ready`=0 is ignored; no state change.

## Test plan
1. Reset, then `instr_addr`=0 → `core_hold`=1, `byte_ready`=0, `instr`=0x00000013, `load_done`=0.
2. `load_start` with `load_len`=2, then bytes 93 00 10 00 13 01 20 00 back-to-back:
   - `load_done` pulses once, cycle after the 8th byte; `core_hold` falls the same cycle.
   - `instr_addr`=0x0 → 0x00100093; 0x4 → 0x00200113.
3. Same load as (2) with random 0–3 cycle `byte_valid` gaps → identical memory contents and a single `load_done`. Extra `load_start` pulses during LOAD have no effect.
4. `load_len`=0 → `load_done` and `core_hold`=0 next cycle, no writes. `load_len`=`DEPTH`+1 → `load_err`=1, state and memory unchanged. A following valid load clears `load_err`.
5. Assert `rst_sync` after 5 bytes of a 2-word load → `core_hold`=1, `byte_ready`=0 immediately. A fresh 1-word load of 13 00 00 00 → `mem[0]`=0x00000013 and `load_done`.
6. In RUN: `instr_addr`=`DEPTH`*4 → 0x00000013; 0x2 → 0x00000013. Reload `load_start` with `load_len`=1 → `core_hold`=1 next cycle; `instr`=NOP until done; `mem[1]` unchanged.
